// File: rtl/user_obi_arbiter.sv
// Round-robin arbiter sharing one user-domain OBI subordinate between NumMgr managers.
// One grant per cycle; an in-order FIFO of granted manager indices routes each response
// back to its issuer. Define USER_OBI_ARB_PERF_EN to add the conflict_cnt_o counter.

package user_obi_arbiter_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 4};

  localparam int unsigned IdW = 4;

  typedef struct packed {
    logic [31:0]    addr;
    logic           we;
    logic [3:0]     be;
    logic [31:0]    wdata;
    logic [IdW-1:0] aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic [31:0]    rdata;
    logic [IdW-1:0] rid;
    logic           err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

module user_obi_arbiter #(
  parameter user_obi_arbiter_pkg::obi_cfg_t ObiCfg = user_obi_arbiter_pkg::ObiDefaultConfig,
  parameter type obi_req_t = user_obi_arbiter_pkg::obi_req_t,
  parameter type obi_rsp_t = user_obi_arbiter_pkg::obi_rsp_t,
  parameter int unsigned NumMgr   = 2,
  parameter int unsigned MaxTrans = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  obi_req_t mgr_req_i [NumMgr],
  output obi_rsp_t mgr_rsp_o [NumMgr],
  output obi_req_t sbr_req_o,
  input  obi_rsp_t sbr_rsp_i
`ifdef USER_OBI_ARB_PERF_EN
  ,
  output logic [31:0] conflict_cnt_o
`endif
);

  localparam int unsigned IdxW = $clog2(NumMgr);
  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  // Field widths come from the struct types; the config is carried for integration only.
  logic unused_cfg;
  assign unused_cfg = ^{ObiCfg.AddrWidth, ObiCfg.DataWidth, ObiCfg.IdWidth};

  logic [IdxW-1:0] prio_q, prio_d;
  logic [IdxW-1:0] fifo_q [MaxTrans];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            any_req;
  logic [IdxW-1:0] win_idx;
  logic            fifo_full, fifo_empty;
  logic            push, pop;
  logic [IdxW-1:0] head_idx;

  // Manager index base + off, wrapped into [0, NumMgr).
  function automatic logic [IdxW-1:0] wrap_add(logic [IdxW-1:0] base, int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NumMgr) sum = sum - NumMgr;
    return IdxW'(sum);
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] ptr);
    return (32'(ptr) == MaxTrans - 1) ? '0 : ptr + PtrW'(1);
  endfunction

  assign fifo_full  = (32'(cnt_q) == MaxTrans);
  assign fifo_empty = (cnt_q == '0);
  assign head_idx   = fifo_q[rd_ptr_q];

  // Winner: first requester scanning upward from prio_q with wrap-around.
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    for (int unsigned i = 0; i < NumMgr; i++) begin
      if (!any_req && mgr_req_i[wrap_add(prio_q, i)].req) begin
        any_req = 1'b1;
        win_idx = wrap_add(prio_q, i);
      end
    end
  end

  // Push is gated by full alone so gnt never depends on rvalid.
  assign push = any_req && !fifo_full && rst_ni && sbr_rsp_i.gnt;
  // rvalid with an empty FIFO is a protocol violation and is dropped.
  assign pop  = sbr_rsp_i.rvalid && !fifo_empty && rst_ni;

  // Next-state for the priority pointer and FIFO bookkeeping.
  always_comb begin
    prio_d   = prio_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      prio_d   = wrap_add(win_idx, 1);
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Registered arbitration and FIFO state; reset discards all outstanding entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(MaxTrans); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      prio_q   <= prio_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= win_idx;
      end
    end
  end

  // Subordinate request: winner's A channel, zero when nobody is requesting.
  always_comb begin
    sbr_req_o     = '0;
    sbr_req_o.req = any_req && !fifo_full && rst_ni;
    if (any_req) begin
      sbr_req_o.a = mgr_req_i[win_idx].a;
    end
  end

  // Manager responses: gnt to the winner on handshake, R channel to the FIFO head on pop.
  always_comb begin
    for (int unsigned m = 0; m < NumMgr; m++) begin
      mgr_rsp_o[m] = '0;
    end
    if (push) begin
      mgr_rsp_o[win_idx].gnt = 1'b1;
    end
    if (pop) begin
      mgr_rsp_o[head_idx].rvalid = 1'b1;
      mgr_rsp_o[head_idx].r      = sbr_rsp_i.r;
    end
  end

`ifdef USER_OBI_ARB_PERF_EN
  logic [31:0] conflict_q, conflict_d;
  logic        multi_req;

  // Detect two or more simultaneous requesters.
  always_comb begin
    logic seen;
    seen      = 1'b0;
    multi_req = 1'b0;
    for (int unsigned i = 0; i < NumMgr; i++) begin
      if (mgr_req_i[i].req) begin
        if (seen) multi_req = 1'b1;
        seen = 1'b1;
      end
    end
  end

  // Saturating contention counter.
  always_comb begin
    conflict_d = conflict_q;
    if (multi_req && (conflict_q != 32'hFFFF_FFFF)) begin
      conflict_d = conflict_q + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_q <= '0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict_cnt_o = conflict_q;
`endif

endmodule

// File: tb/tb_user_obi_arbiter.sv
// Randomized bench for user_obi_arbiter against a queue-based round-robin reference model.
module tb_user_obi_arbiter;
  import user_obi_arbiter_pkg::*;

  localparam int unsigned NumMgr   = 3;
  localparam int unsigned MaxTrans = 2;
  localparam int NM = int'(NumMgr);

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  obi_req_t mgr_req [NumMgr];
  obi_rsp_t mgr_rsp [NumMgr];
  obi_req_t sbr_req;
  obi_rsp_t sbr_rsp;
`ifdef USER_OBI_ARB_PERF_EN
  logic [31:0] conflict_cnt;
`endif

  always #5 clk = ~clk;

  user_obi_arbiter #(
    .ObiCfg   (ObiDefaultConfig),
    .obi_req_t(obi_req_t),
    .obi_rsp_t(obi_rsp_t),
    .NumMgr   (NumMgr),
    .MaxTrans (MaxTrans)
  ) u_dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .mgr_req_i(mgr_req),
    .mgr_rsp_o(mgr_rsp),
    .sbr_req_o(sbr_req),
    .sbr_rsp_i(sbr_rsp)
`ifdef USER_OBI_ARB_PERF_EN
    ,
    .conflict_cnt_o(conflict_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int          prio;
  int          own_q[$];   // manager index of each outstanding transaction, oldest first
  obi_r_chan_t pend_q[$];  // responses the subordinate still owes, oldest first
  logic [31:0] exp_cnt;
  logic [31:0] rom [16];
  bit          rom_phase;
  int          rom_issue;
  int          rom_rx;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    prio = 0;
    own_q.delete();
    pend_q.delete();
    exp_cnt = '0;
  endtask

  // Modes: 0 random, 1 mgr1 ROM reads, 2 all request, 3 all request without rvalid, 4 idle.
  task automatic drive(input int mode);
    for (int m = 0; m < NM; m++) mgr_req[m] = '0;
    case (mode)
      0: for (int m = 0; m < NM; m++) begin
        if ($urandom_range(0, 9) < 6) begin
          mgr_req[m].req     = 1'b1;
          mgr_req[m].a.addr  = $urandom & 32'hFFFF_FFFC;
          mgr_req[m].a.we    = 1'($urandom_range(0, 1));
          mgr_req[m].a.be    = 4'($urandom);
          mgr_req[m].a.wdata = $urandom;
          mgr_req[m].a.aid   = IdW'($urandom);
        end
      end
      1: if (rom_issue < 4) begin
        mgr_req[1].req    = 1'b1;
        mgr_req[1].a.addr = 32'(rom_issue * 4);
        mgr_req[1].a.be   = 4'hF;
        mgr_req[1].a.aid  = IdW'(rom_issue);
      end
      2, 3: for (int m = 0; m < NM; m++) begin
        mgr_req[m].req    = 1'b1;
        mgr_req[m].a.addr = $urandom & 32'h0000_003C;
        mgr_req[m].a.aid  = IdW'(m);
      end
      default: ;
    endcase
    sbr_rsp     = '0;
    sbr_rsp.gnt = (mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (mode != 3) begin
      if (pend_q.size() > 0) begin
        if (mode != 0 || $urandom_range(0, 9) < 6) begin
          sbr_rsp.rvalid = 1'b1;
          sbr_rsp.r      = pend_q.pop_front();
        end
      end else if (mode == 0 && $urandom_range(0, 9) == 0) begin
        sbr_rsp.rvalid  = 1'b1;  // spurious response with nothing outstanding
        sbr_rsp.r.rdata = $urandom;
        sbr_rsp.r.rid   = IdW'($urandom);
        sbr_rsp.r.err   = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // Compare DUT outputs against the model for the current inputs, then advance the model.
  task automatic eval_cycle();
    int          win, n_req, owner;
    logic        exp_req, hs;
    obi_a_chan_t exp_a;
    obi_r_chan_t rr;
    win = -1; n_req = 0; owner = -1;
    for (int k = 0; k < NM; k++) begin
      int idx;
      idx = (prio + k) % NM;
      if (mgr_req[idx].req) begin
        n_req++;
        if (win < 0) win = idx;
      end
    end
    exp_req = (win >= 0) && (own_q.size() < int'(MaxTrans));
    exp_a   = (win >= 0) ? mgr_req[win].a : '0;
    hs      = exp_req && sbr_rsp.gnt;
    if (sbr_rsp.rvalid && own_q.size() > 0) owner = own_q[0];

    check_eq("sbr_req", 128'(sbr_req.req), 128'(exp_req));
    check_eq("sbr_a", 128'(sbr_req.a), 128'(exp_a));
    for (int m = 0; m < NM; m++) begin
      check_eq($sformatf("gnt%0d", m), 128'(mgr_rsp[m].gnt), 128'(hs && (m == win)));
      check_eq($sformatf("rvalid%0d", m), 128'(mgr_rsp[m].rvalid), 128'(m == owner));
      check_eq($sformatf("r%0d", m), 128'(mgr_rsp[m].r),
               (m == owner) ? 128'(sbr_rsp.r) : 128'(0));
    end
    if (rom_phase && owner == 1) begin
      check_eq("rom_rdata", 128'(mgr_rsp[1].r.rdata), 128'(rom[rom_rx]));
      check_eq("rom_rid", 128'(mgr_rsp[1].r.rid), 128'(rom_rx));
      rom_rx++;
    end
`ifdef USER_OBI_ARB_PERF_EN
    check_eq("conflict", 128'(conflict_cnt), 128'(exp_cnt));
    if (n_req >= 2 && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
`endif

    if (owner >= 0) void'(own_q.pop_front());
    if (hs) begin
      own_q.push_back(win);
      prio = (win + 1) % NM;
      rr.rdata = rom[mgr_req[win].a.addr[5:2]];
      rr.rid   = mgr_req[win].a.aid;
      rr.err   = mgr_req[win].a.we & mgr_req[win].a.addr[6];
      pend_q.push_back(rr);
      if (rom_phase && win == 1) rom_issue++;
    end
  endtask

  task automatic run_cycle(input int mode);
    @(posedge clk);
    #1;
    drive(mode);
    @(negedge clk);
    eval_cycle();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_req"}, 128'(sbr_req.req), 128'(0));
    for (int m = 0; m < NM; m++) begin
      check_eq($sformatf("%s_gnt%0d", tag, m), 128'(mgr_rsp[m].gnt), 128'(0));
      check_eq($sformatf("%s_rvalid%0d", tag, m), 128'(mgr_rsp[m].rvalid), 128'(0));
    end
  endtask

  initial begin
    int guard;
    rom[0] = 32'h4A61_6B75;
    rom[1] = 32'h6220_616E;
    rom[2] = 32'h6420_4164;
    rom[3] = 32'h6974_7961;
    for (int i = 4; i < 16; i++) rom[i] = 32'h1357_9BDF ^ (32'(i) * 32'h0101_0101);
    rom_phase = 1'b0; rom_issue = 0; rom_rx = 0;
    for (int m = 0; m < NM; m++) mgr_req[m] = '0;
    sbr_rsp = '0;
    model_reset();

    // Reset state, held and after release with no requesters.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("in_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_rst");
`ifdef USER_OBI_ARB_PERF_EN
    check_eq("rst_conflict", 128'(conflict_cnt), 128'(0));
`endif

    // Manager 1 alone: four back-to-back ROM reads.
    rom_phase = 1'b1;
    repeat (4) run_cycle(1);
    check_eq("rom_grants", 128'(rom_issue), 128'(4));
    repeat (2) run_cycle(4);
    check_eq("rom_resps", 128'(rom_rx), 128'(4));
    rom_phase = 1'b0;

    // All managers requesting: round-robin fairness.
    repeat (8) run_cycle(2);
    repeat (2) run_cycle(4);

    // Randomized traffic including stalls, full FIFO and spurious responses.
    repeat (2000) run_cycle(0);

    // Reset with outstanding transactions.
    guard = 0;
    while (own_q.size() < int'(MaxTrans) && guard < 20) begin
      run_cycle(3);
      guard++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    sbr_rsp.rvalid  = 1'b1;
    sbr_rsp.r.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_idle_outputs("mid_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    sbr_rsp = '0;
    run_cycle(2);
    check_eq("rst_first_gnt0", 128'(mgr_rsp[0].gnt), 128'(1));
    repeat (6) run_cycle(2);
    repeat (200) run_cycle(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/user_obi_arbiter.md
# user_obi_arbiter

Round-robin OBI arbiter that shares one user-domain OBI subordinate, such as the user ROM or another single-port peripheral, between `NumMgr` manager ports. Requests are granted one per cycle. The index of each granted manager is stored in an in-order FIFO so that each subordinate response is routed back to the manager that issued it. The arbiter sits in the user domain between the user crossbar demux outputs and the shared subordinate.

## Interface
Parameters:
- `ObiCfg`, `obi_pkg::ObiDefaultConfig`: OBI configuration shared by all ports.
- `obi_req_t`, `logic`: OBI request struct type.
- `obi_rsp_t`, `logic`: OBI response struct type.
- `NumMgr`, 2: number of manager ports, at least 2.
- `MaxTrans`, 2: depth of the outstanding-transaction FIFO, at least 1.

Ports:
- `clk_i`, input, 1: clock. The block has one clock.
- `rst_ni`, input, 1: asynchronous, active-low reset.
- `mgr_req_i`, input, `obi_req_t [NumMgr]`: requests from the managers.
- `mgr_rsp_o`, output, `obi_rsp_t [NumMgr]`: responses to the managers.
- `sbr_req_o`, output, `obi_req_t`: request to the shared subordinate.
- `sbr_rsp_i`, input, `obi_rsp_t`: response from the shared subordinate.
- `conflict_cnt_o`, output, 32: contention counter. This port exists only when `USER_OBI_ARB_PERF_EN` is defined (see Configuration).

## Operation
- **Priority pointer:** `prio_q` is `$clog2(NumMgr)` bits wide and resets to 0.
- **Winner selection:** the winner is the first requesting manager found by scanning upward from `prio_q`, wrapping from `NumMgr-1` to 0.
- **Pointer update:** on every A-channel handshake (`sbr_req_o.req && sbr_rsp_i.gnt`), `prio_q` becomes the winner index + 1, wrapping modulo `NumMgr`.
- **Subordinate request:**
  - `sbr_req_o.req` = (any manager `req`) AND NOT `fifo_full`.
  - `sbr_req_o.a` = the winner's `a` field.
  - When no manager is requesting, `sbr_req_o.a` = '0.
- **Manager grant:**
  - The winner receives `mgr_rsp_o[w].gnt = sbr_rsp_i.gnt && !fifo_full`.
  - All other managers receive `gnt` = 0.
- **FIFO push:** on a handshake, the winner index is pushed into the FIFO (`MaxTrans` entries).
- **FIFO push while full:** a push is blocked whenever the FIFO is full, even if a pop occurs in the same cycle. This is a deliberate choice that keeps the grant path free of any combinational dependence on `rvalid`.
- **FIFO pop:** when `sbr_rsp_i.rvalid` = 1, the FIFO head `h` is popped.
  - `mgr_rsp_o[h].rvalid` = 1.
  - `mgr_rsp_o[h].r` = `sbr_rsp_i.r`, with `rid` passed through unchanged.
- **Non-owner response fields:** every manager other than `h` receives `rvalid` = 0 and `r` = '0.
- **Simultaneous push and pop** with the FIFO not full: both take effect and the occupancy count is unchanged.
- **`rvalid` with the FIFO empty:** this is a protocol violation. The response is dropped, no manager sees `rvalid`, and occupancy stays 0 (no underflow).
- **Write requests** are arbitrated exactly like reads. Error signalling is the subordinate's responsibility and the arbiter only passes `r.err` through.
- **Reset state:**
  - `prio_q` = 0.
  - FIFO empty, with read and write pointers at 0.
  - All `mgr_rsp_o` `gnt`/`rvalid` outputs = 0 while `rst_ni` is low.
  - `sbr_req_o.req` = 0 while `rst_ni` is low.
- **Reset during a transaction:** reset asserted mid-transaction discards all outstanding FIFO entries. Responses arriving after reset are treated as the empty-FIFO case above.

## Timing
- **Request path:** combinational from `mgr_req_i` to `sbr_req_o`, and from `sbr_rsp_i.gnt` to the manager `gnt`. Arbitration adds zero cycles.
- **Response path:** combinational from `sbr_rsp_i` to `mgr_rsp_o`, with zero added latency. A subordinate with N-cycle read latency gives the same N-cycle latency at the manager.
- **Registered state:** `prio_q`, the FIFO storage, the FIFO pointers and the occupancy count. All of these update on the rising edge of `clk_i`.
- **Throughput:** one grant per cycle while `MaxTrans` ≥ subordinate latency + 1. With `MaxTrans` = 1 and a 1-cycle subordinate, a grant is possible at most every other cycle.
- **Fairness:** with all `NumMgr` managers requesting continuously, each is granted exactly once per `NumMgr` handshakes.

## Configuration
- **`USER_OBI_ARB_PERF_EN` defined:** the `conflict_cnt_o` port exists.
  - It increments by 1 in each cycle in which two or more managers have `req` = 1.
  - It saturates at `32'hFFFF_FFFF` and resets to 0.
- **`USER_OBI_ARB_PERF_EN` undefined:** the port, the counter register and the request-count logic are absent. Arbitration behaviour is identical in both builds.

## Test plan
- **Reset:** after reset, no manager requests → `sbr_req_o.req` = 0, all `gnt`/`rvalid` = 0, `conflict_cnt_o` = 0.
- **Single manager:** manager 1 alone issues 4 back-to-back reads to 0x0, 0x4, 0x8, 0xC of a 1-cycle ROM with `MaxTrans` = 2 → 4 grants on 4 consecutive cycles, and manager 1 receives rdata `4A616B75`, `6220616E`, `64204164`, `69747961` with matching `rid`. Manager 0 never sees `rvalid`.
- **Round-robin:** both managers request continuously for 8 cycles → grants alternate 0,1,0,1…. Each response is delivered to its issuer in order. `conflict_cnt_o` = 8 (PERF build).
- **FIFO full:** `MaxTrans` = 1 with a subordinate that delays `rvalid` by 3 cycles → a second request is not granted until the cycle after `rvalid`, and no response is misrouted.
- **Spurious response:** `rvalid` pulsed with the FIFO empty → no manager `rvalid`, and a subsequent normal read completes correctly.
- **Reset mid-transaction:** `rst_ni` asserted with 2 entries outstanding → FIFO empty and `prio_q` = 0 after release, and the next grant goes to manager 0.
